sram_bus_arbiter: RTL

//  Shares one single-outstanding SRAM-like bus between the IF fetch port and the EX/MEM data port.

---
 rtl/sram_bus_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Purpose  : Shares one single-outstanding SRAM-like bus between the IF fetch
//            port and the EX/MEM data port. Requesters use req/addr_ok/data_ok.
//            Each accepted command is latched, then issued on the bus, and the
//            response is routed back to the port that owns it.
//            The data port wins by default. A starvation counter forces a
//            fetch grant after MAX_STARVE data grants made while a fetch waits.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   inst_req/addr            fetch request (read only)
//   inst_addr_ok/data_ok     fetch accept / data-valid pulses
//   inst_rdata               fetch data, zero unless inst_data_ok
//   data_req/wr/wstrb/addr/wdata  data-port command
//   data_addr_ok/data_ok     data accept / data-valid-or-write-done pulses
//   data_rdata               read data, zero unless data_data_ok
//   bus_req/wr/wstrb/addr/wdata   registered bus command
//   bus_addr_ok/data_ok/rdata     bus accept / response
//   busy                     arbiter not idle
// Optional build macro
//   ARB_PERF_CNT_EN : adds perf_inst_cnt, perf_data_cnt (grant counts) and
//                     perf_wait_cnt (cycles spent waiting for a bus response).
// ============================================================================
module sram_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  // data port
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // shared bus
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]         perf_inst_cnt,
  output logic [31:0]         perf_data_cnt,
  output logic [31:0]         perf_wait_cnt,
`endif
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic                owner_q,     owner_d;     // 0 = inst, 1 = data
  logic                wr_q,        wr_d;
  logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                bus_req_q,   bus_req_d;
  logic                busy_q,      busy_d;

  logic grant_window;
  logic starve_hit;
  logic grant_inst;
  logic grant_data;
  logic resp;

  // Arbitration and next-state logic.
  always_comb begin
    // A grant may happen when idle, or in the very cycle the outstanding
    // response returns so back-to-back commands see no bubble. Reset gates
    // the accept pulses so nothing is acknowledged while rst is asserted.
    grant_window = rst && ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && bus_data_ok));
    starve_hit   = (starve_cnt_q == CNT_W'(MAX_STARVE));
    grant_inst   = grant_window && inst_req && (!data_req || starve_hit);
    grant_data   = grant_window && data_req && !grant_inst;
    resp         = (state_q == ST_WAIT) && bus_data_ok;

    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_inst || grant_data) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus_addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_data_ok) state_d = (grant_inst || grant_data) ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_inst) begin
      owner_d = 1'b0;
      wr_d    = 1'b0;
      wstrb_d = '0;
      addr_d  = inst_addr;
      wdata_d = '0;
    end else if (grant_data) begin
      owner_d = 1'b1;
      wr_d    = data_wr;
      wstrb_d = data_wstrb;
      addr_d  = data_addr;
      wdata_d = data_wdata;
    end

    // Count data grants that bypass a waiting fetch; any other grant clears.
    if (grant_data && inst_req) begin
      if (!starve_hit) starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else if (grant_inst || grant_data) begin
      starve_cnt_d = '0;
    end

    bus_req_d = (state_d == ST_ISSUE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
      bus_req_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      bus_req_q    <= bus_req_d;
      busy_q       <= busy_d;
    end
  end

  // Requester-side handshakes are combinational so accept and response
  // pulses land in the same cycle as the grant / bus response.
  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = resp && !owner_q;
  assign data_data_ok = resp &&  owner_q;
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;

  // The bus command comes straight from flops, stable for the whole issue.
  assign bus_req   = bus_req_q;
  assign bus_wr    = wr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = busy_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_inst_cnt_q, perf_inst_cnt_d;
  logic [31:0] perf_data_cnt_q, perf_data_cnt_d;
  logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;

  always_comb begin
    perf_inst_cnt_d = perf_inst_cnt_q + (grant_inst ? 32'd1 : 32'd0);
    perf_data_cnt_d = perf_data_cnt_q + (grant_data ? 32'd1 : 32'd0);
    perf_wait_cnt_d = perf_wait_cnt_q + ((state_q == ST_WAIT) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_inst_cnt_q <= '0;
      perf_data_cnt_q <= '0;
      perf_wait_cnt_q <= '0;
    end else begin
      perf_inst_cnt_q <= perf_inst_cnt_d;
      perf_data_cnt_q <= perf_data_cnt_d;
      perf_wait_cnt_q <= perf_wait_cnt_d;
    end
  end

  assign perf_inst_cnt = perf_inst_cnt_q;
  assign perf_data_cnt = perf_data_cnt_q;
  assign perf_wait_cnt = perf_wait_cnt_q;
`endif

endmodule
`default_nettype wire
